// File: rtl/ipu_centroid_tracker.sv
// Per-channel blob centroid tracker: accumulates mask statistics per frame, divides
// sums by counts with one shared restoring divider, and smooths results with an EMA.
module ipu_centroid_tracker #(
  parameter int NUM_CH     = 2,
  parameter int COORD_W    = 11,
  parameter int CNT_W      = 21,
  parameter int AVG_SHIFT  = 2,
  parameter int MIN_PIXELS = 16
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iDVAL,
  input  logic [NUM_CH-1:0]         iMask,
  input  logic [COORD_W-1:0]        iX_Cont,
  input  logic [COORD_W-1:0]        iY_Cont,
  input  logic                      iFrameEnd,
  output logic [NUM_CH*COORD_W-1:0] oX,
  output logic [NUM_CH*COORD_W-1:0] oY,
  output logic [NUM_CH-1:0]         oFound,
  output logic                      oDVAL,
  output logic                      oBusy,
  output logic                      oDrop
);

  localparam int SUM_W = COORD_W + CNT_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(COORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_DIV_X, S_LOAD_Y, S_DIV_Y, S_UPDATE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q;
  logic [BIT_W-1:0]   bit_q;
  logic               last_ch, last_bit, frame_start, found_now;

  logic [CNT_W-1:0]   cnt_acc [NUM_CH];
  logic [SUM_W-1:0]   sx_acc  [NUM_CH];
  logic [SUM_W-1:0]   sy_acc  [NUM_CH];
  logic [CNT_W-1:0]   cnt_nx  [NUM_CH];
  logic [SUM_W-1:0]   sx_nx   [NUM_CH];
  logic [SUM_W-1:0]   sy_nx   [NUM_CH];
  logic [CNT_W-1:0]   snap_cnt[NUM_CH];
  logic [SUM_W-1:0]   snap_sx [NUM_CH];
  logic [SUM_W-1:0]   snap_sy [NUM_CH];

  logic [COORD_W-1:0] x_s   [NUM_CH];
  logic [COORD_W-1:0] y_s   [NUM_CH];
  logic [NUM_CH-1:0]  found_s;
  logic [COORD_W-1:0] out_x [NUM_CH];
  logic [COORD_W-1:0] out_y [NUM_CH];
  logic [NUM_CH-1:0]  found_o;
  logic               dval_q, drop_q;

  logic [CNT_W-1:0]   rem_q, rem_nx;
  logic [COORD_W-1:0] quo_q, qx_q;
  logic [CNT_W-1:0]   div_q;
  logic [CNT_W:0]     shifted;
  logic               take;

  function automatic logic [COORD_W-1:0] ema_step(input logic [COORD_W-1:0] prev,
                                                  input logic [COORD_W-1:0] sample);
    logic signed [COORD_W:0] diff;
    logic signed [COORD_W:0] acc;
    diff = $signed({1'b0, sample}) - $signed({1'b0, prev});
    acc  = $signed({1'b0, prev}) + (diff >>> AVG_SHIFT);
    return COORD_W'(acc);
  endfunction

  assign frame_start = iFrameEnd && (state_q == S_IDLE);
  assign last_ch     = (ch_q == CH_W'(NUM_CH - 1));
  assign last_bit    = (bit_q == BIT_W'(COORD_W - 1));
  assign found_now   = (snap_cnt[ch_q] >= CNT_W'(MIN_PIXELS));

  // Accumulate stage: a saturated counter freezes its whole channel until frame end
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_nx[c] = cnt_acc[c];
      sx_nx[c]  = sx_acc[c];
      sy_nx[c]  = sy_acc[c];
      if (iDVAL && iMask[c] && (cnt_acc[c] != '1)) begin
        cnt_nx[c] = cnt_acc[c] + CNT_W'(1);
        sx_nx[c]  = sx_acc[c] + SUM_W'(iX_Cont);
        sy_nx[c]  = sy_acc[c] + SUM_W'(iY_Cont);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_acc[c]  <= '0;
        sx_acc[c]   <= '0;
        sy_acc[c]   <= '0;
        snap_cnt[c] <= '0;
        snap_sx[c]  <= '0;
        snap_sy[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_acc[c] <= iFrameEnd ? '0 : cnt_nx[c];
        sx_acc[c]  <= iFrameEnd ? '0 : sx_nx[c];
        sy_acc[c]  <= iFrameEnd ? '0 : sy_nx[c];
        if (frame_start) begin
          snap_cnt[c] <= cnt_nx[c];
          snap_sx[c]  <= sx_nx[c];
          snap_sy[c]  <= sy_nx[c];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (iFrameEnd) state_d = S_LOAD_X;
      S_LOAD_X: state_d = S_DIV_X;
      S_DIV_X:  if (last_bit) state_d = S_LOAD_Y;
      S_LOAD_Y: state_d = S_DIV_Y;
      S_DIV_Y:  if (last_bit) state_d = S_UPDATE;
      S_UPDATE: state_d = last_ch ? S_DONE : S_LOAD_X;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= (state_q == S_DIV_X || state_q == S_DIV_Y) ? bit_q + BIT_W'(1) : '0;
      if (state_q == S_IDLE)
        ch_q <= '0;
      else if (state_q == S_UPDATE && !last_ch)
        ch_q <= ch_q + CH_W'(1);
    end
  end

  // Divide stage: remainder starts as the upper sum bits; it is always below the
  // count because the mean coordinate fits COORD_W bits
  assign shifted = {rem_q, quo_q[COORD_W-1]};
  assign take    = (shifted >= {1'b0, div_q});
  assign rem_nx  = take ? CNT_W'(shifted - {1'b0, div_q}) : CNT_W'(shifted);

  always_ff @(posedge iCLK) begin
    unique case (state_q)
      S_LOAD_X: begin
        rem_q <= snap_sx[ch_q][SUM_W-1:COORD_W];
        quo_q <= snap_sx[ch_q][COORD_W-1:0];
        div_q <= snap_cnt[ch_q];
      end
      S_LOAD_Y: begin
        qx_q  <= quo_q;
        rem_q <= snap_sy[ch_q][SUM_W-1:COORD_W];
        quo_q <= snap_sy[ch_q][COORD_W-1:0];
        div_q <= snap_cnt[ch_q];
      end
      S_DIV_X, S_DIV_Y: begin
        rem_q <= rem_nx;
        quo_q <= {quo_q[COORD_W-2:0], take};
      end
      default: ;
    endcase
  end

  // Update/commit stage: staging smooths per channel, outputs commit all at once
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        x_s[c]   <= '0;
        y_s[c]   <= '0;
        out_x[c] <= '0;
        out_y[c] <= '0;
      end
      found_s <= '0;
      found_o <= '0;
      dval_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (state_q == S_UPDATE) begin
        if (!found_now) begin
          found_s[ch_q] <= 1'b0;
        end else begin
          found_s[ch_q] <= 1'b1;
          x_s[ch_q]     <= found_s[ch_q] ? ema_step(x_s[ch_q], qx_q)  : qx_q;
          y_s[ch_q]     <= found_s[ch_q] ? ema_step(y_s[ch_q], quo_q) : quo_q;
        end
      end
      if (state_q == S_DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          out_x[c] <= x_s[c];
          out_y[c] <= y_s[c];
        end
        found_o <= found_s;
      end
      dval_q <= (state_q == S_DONE);
      drop_q <= iFrameEnd && (state_q != S_IDLE);
    end
  end

  always_comb begin
    oX = '0;
    oY = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      oX[c*COORD_W +: COORD_W] = out_x[c];
      oY[c*COORD_W +: COORD_W] = out_y[c];
    end
  end

  assign oFound = found_o;
  assign oDVAL  = dval_q;
  assign oDrop  = drop_q;
  assign oBusy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ipu_centroid_tracker.sv
// Bench for ipu_centroid_tracker: table of frames with hand-derived centroids,
// expected results queued at frame end and compared when oDVAL fires.
module tb_ipu_centroid_tracker;

  localparam int LAT = 52;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iDVAL = 1'b0;
  logic [1:0]  iMask = '0;
  logic [10:0] iX_Cont = '0;
  logic [10:0] iY_Cont = '0;
  logic        iFrameEnd = 1'b0;
  logic [21:0] oX, oY;
  logic [1:0]  oFound;
  logic        oDVAL, oBusy, oDrop;

  ipu_centroid_tracker dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iMask(iMask),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFrameEnd(iFrameEnd),
    .oX(oX), .oY(oY), .oFound(oFound), .oDVAL(oDVAL), .oBusy(oBusy), .oDrop(oDrop)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] x0, y0, x1, y1;
    logic [1:0]  found;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  mask;
    int          x0, y0, npix;
    logic [10:0] ex0, ey0, ex1, ey1;
    logic [1:0]  efound;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t none_e;
  int n_checks = 0, n_err = 0, drops_seen = 0, dvals_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge iCLK) begin
    if (oDrop) drops_seen++;
    if (oDVAL) begin
      dvals_seen++;
      if (sb.size() == 0) begin
        check("spurious_dval", oDVAL, 0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.due);
        check("x_ch0", oX[10:0], mon_e.x0);
        check("y_ch0", oY[10:0], mon_e.y0);
        check("x_ch1", oX[21:11], mon_e.x1);
        check("y_ch1", oY[21:11], mon_e.y1);
        check("found", oFound, mon_e.found);
      end
    end
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Pixels i in [from,to) of a 4-wide raster block; optional frame end on the last one
  task automatic drive_pixels(input logic [1:0] mask, input int x0, input int y0,
                              input int from, input int to, input bit end_frame,
                              input bit push, input exp_t e);
    exp_t q;
    q = e;
    if (from == to && end_frame) begin
      iDVAL = 1'b0; iFrameEnd = 1'b1;
      if (push) begin q.due = cyc + LAT; sb.push_back(q); end
      step();
    end
    for (int i = from; i < to; i++) begin
      if (i % 5 == 4) begin
        iDVAL = 1'b0; iFrameEnd = 1'b0;
        iMask = 2'($urandom); iX_Cont = 11'($urandom); iY_Cont = 11'($urandom);
        step();
      end
      iDVAL = 1'b1; iMask = mask;
      iX_Cont = 11'(x0 + i % 4); iY_Cont = 11'(y0 + i / 4);
      iFrameEnd = end_frame && (i == to - 1);
      if (iFrameEnd && push) begin q.due = cyc + LAT; sb.push_back(q); end
      step();
    end
    iDVAL = 1'b0; iFrameEnd = 1'b0; iMask = '0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!oBusy && sb.size() == 0) return;
      step();
    end
    n_checks++; n_err++;
    $display("FAIL timeout_%s: actual=busy/pending expected=idle", name);
  endtask

  vec_t tbl[8];
  exp_t e;
  int   dv_before;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    none_e = '{default: '0};
    tbl[0] = '{2'b01,  100,   50, 16, 11'd101, 11'd51,  11'd0,   11'd0,   2'b01};
    tbl[1] = '{2'b01,  200,   50, 16, 11'd126, 11'd51,  11'd0,   11'd0,   2'b01};
    tbl[2] = '{2'b01,    0,   50, 16, 11'd94,  11'd51,  11'd0,   11'd0,   2'b01};
    tbl[3] = '{2'b01,  100,   50, 15, 11'd94,  11'd51,  11'd0,   11'd0,   2'b00};
    tbl[4] = '{2'b01,  299,   99, 16, 11'd300, 11'd100, 11'd0,   11'd0,   2'b01};
    tbl[5] = '{2'b11,   40,   20, 16, 11'd235, 11'd80,  11'd41,  11'd21,  2'b11};
    tbl[6] = '{2'b10, 2040, 1000, 16, 11'd235, 11'd80,  11'd541, 11'd266, 2'b10};
    tbl[7] = '{2'b00,    0,    0,  0, 11'd235, 11'd80,  11'd541, 11'd266, 2'b00};

    // Reset held with random traffic
    for (int i = 0; i < 10; i++) begin
      iDVAL = 1'($urandom); iMask = 2'($urandom); iFrameEnd = 1'($urandom);
      iX_Cont = 11'($urandom); iY_Cont = 11'($urandom);
      @(negedge iCLK);
      if (i >= 8) begin
        check("rst_oX", oX, 0);
        check("rst_oY", oY, 0);
        check("rst_oFound", oFound, 0);
        check("rst_oDVAL", oDVAL, 0);
        check("rst_oBusy", oBusy, 0);
        check("rst_oDrop", oDrop, 0);
      end
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b0; iFrameEnd = 1'b0; iMask = '0;
    step();
    iRST = 1'b1;
    for (int i = 0; i < 60; i++) begin
      iMask = 2'($urandom); iX_Cont = 11'($urandom);
      step();
    end
    iMask = '0;
    check("no_dval_without_frame_end", dvals_seen, 0);
    check("idle_busy", oBusy, 0);

    // Table frames, frame end coincides with the last pixel
    foreach (tbl[r]) begin
      e = '{tbl[r].ex0, tbl[r].ey0, tbl[r].ex1, tbl[r].ey1, tbl[r].efound, 0};
      drive_pixels(tbl[r].mask, tbl[r].x0, tbl[r].y0, 0, tbl[r].npix, 1'b1, 1'b1, e);
      wait_idle($sformatf("row%0d", r));
    end

    // Overlapping frame end is dropped; its pixels vanish, later pixels carry over
    e = '{11'd235, 11'd80, 11'd501, 11'd501, 2'b10, 0};
    drive_pixels(2'b10, 500, 500, 0, 16, 1'b1, 1'b1, e);
    for (int i = 1; i < 20; i++) begin
      iDVAL = (i <= 10); iMask = 2'b01; iX_Cont = 11'd5; iY_Cont = 11'd7;
      step();
    end
    iDVAL = 1'b0; iFrameEnd = 1'b1;
    step();
    iFrameEnd = 1'b0;
    drive_pixels(2'b01, 600, 600, 0, 8, 1'b0, 1'b0, none_e);
    for (int i = 0; i < 100 && oBusy; i++) step();
    check("busy_after_done", oBusy, 0);
    e = '{11'd601, 11'd601, 11'd501, 11'd501, 2'b01, 0};
    drive_pixels(2'b01, 600, 600, 8, 16, 1'b1, 1'b1, e);
    wait_idle("drop_seq");
    check("drop_count", drops_seen, 1);

    // Reset in the middle of a sequence aborts it
    dv_before = dvals_seen;
    drive_pixels(2'b01, 10, 10, 0, 16, 1'b1, 1'b0, none_e);
    for (int i = 0; i < 29; i++) step();
    check("busy_mid_seq", oBusy, 1);
    iRST = 1'b0;
    @(negedge iCLK);
    check("abort_oX", oX, 0);
    check("abort_oY", oY, 0);
    check("abort_oFound", oFound, 0);
    check("abort_oBusy", oBusy, 0);
    step(); step();
    iRST = 1'b1;
    for (int i = 0; i < 70; i++) step();
    check("abort_no_dval", dvals_seen, dv_before);
    check("abort_oX_after", oX, 0);

    // Fresh acquisition after the abort
    e = '{11'd101, 11'd51, 11'd0, 11'd0, 2'b01, 0};
    drive_pixels(2'b01, 100, 50, 0, 16, 1'b1, 1'b1, e);
    wait_idle("post_abort");

    check("dval_total", dvals_seen, 11);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ipu_centroid_tracker.md
# ipu_centroid_tracker

Multi-channel blob tracker that sits after the colour filter in the image processing unit. It accumulates per-channel pixel-mask statistics over a frame, computes each channel's centroid with a shared sequential divider, and smooths the result across frames with an exponential moving average. It produces stable per-channel X/Y coordinates and a found/lost flag for the downstream controller.

## Interface
Parameters:
- NUM_CH, 2: number of independent colour channels / mask bits.
- COORD_W, 11: width of X/Y coordinates.
- CNT_W, 21: width of the per-channel pixel counter. Sums are COORD_W+CNT_W bits wide.
- AVG_SHIFT, 2: EMA weight 2^-AVG_SHIFT. A value of 0 disables smoothing.
- MIN_PIXELS, 16: minimum pixel count for a channel to be "found". Must be ≥1.

Ports (reset iRST, asynchronous, active-low; clock iCLK):
- iCLK  in  1  clock
- iRST  in  1  async active-low reset
- iDVAL  in  1  pixel valid
- iMask  in  NUM_CH  per-channel filter hit for the current pixel
- iX_Cont  in  COORD_W  pixel column
- iY_Cont  in  COORD_W  pixel row
- iFrameEnd  in  1  one-cycle pulse marking end of frame
- oX  out  NUM_CH*COORD_W  smoothed X per channel; channel c occupies bits [c*COORD_W +: COORD_W]
- oY  out  NUM_CH*COORD_W  smoothed Y per channel, same packing
- oFound  out  NUM_CH  channel met MIN_PIXELS in the last processed frame
- oDVAL  out  1  one-cycle pulse when oX/oY/oFound commit
- oBusy  out  1  divider sequence in progress
- oDrop  out  1  one-cycle pulse when a frame is discarded

## Operation
- Accumulate: on each cycle with iDVAL=1 and iMask[c]=1, add 1 to cnt[c], iX_Cont to sx[c], and iY_Cont to sy[c]. If cnt[c] is all-ones, channel c freezes (cnt, sx and sy all stop) until the next frame end.
- Frame end while idle (iFrameEnd=1, oBusy=0):
  - cnt/sx/sy are copied into snapshot registers. The copy includes any pixel accumulated in the same cycle.
  - Accumulators clear to 0.
  - FSM leaves IDLE.
- Frame end while busy: no snapshot is taken, accumulators clear, oDrop pulses for 1 cycle, and the running computation continues unaffected.
- FSM: IDLE → LOAD_X → DIV_X → LOAD_Y → DIV_Y → UPDATE → (next channel: LOAD_X | last channel: DONE) → IDLE.
  - LOAD_X, LOAD_Y, UPDATE and DONE each last 1 cycle.
  - DIV_X and DIV_Y each last exactly COORD_W cycles.
  - Channels are processed in order 0..NUM_CH-1.
- Divider: restoring, unsigned, one quotient bit per cycle, COORD_W iterations. Quotient = floor(sum/cnt), truncated to COORD_W bits. Divide-by-zero is never consumed, because the channel is lost in that case.
- UPDATE for channel c writes staging registers:
  - cnt < MIN_PIXELS: found_s[c]=0; x_s/y_s hold their previous value.
  - found, and previous found_s[c]=0 (first frame after reset or after loss): x_s = qx, y_s = qy, loaded directly.
  - found, and previous found_s[c]=1: x_s ← x_s + ((qx − x_s) >>> AVG_SHIFT). This uses signed arithmetic in COORD_W+1 bits with an arithmetic shift (floor); the same rule applies to y_s.
- DONE: staging copies to oX/oY/oFound for all channels simultaneously, and oDVAL=1.
- oBusy=1 in every state except IDLE.

## Timing
- Reset values:
  - oX, oY, oFound all 0.
  - oDVAL=0, oBusy=0, oDrop=0.
  - Accumulators, snapshots and staging cleared; FSM in IDLE.
- Latency: if iFrameEnd is sampled high at edge k, oDVAL is high in the cycle following edge k + NUM_CH*(2*COORD_W+3) + 1. With defaults this is 51 cycles after the iFrameEnd cycle.
- Outputs change only in the DONE cycle and are stable between oDVAL pulses.
- oBusy returns to 0 in the cycle after DONE. An iFrameEnd coincident with DONE counts as busy and is dropped.
- iRST asserted mid-sequence aborts immediately: the pending frame is lost, all outputs return to reset values, and no oDVAL is emitted.
- Accumulation continues every cycle regardless of FSM state.

## Test plan
- Reset: hold iRST=0, drive random pixels → all outputs 0, oBusy=0. Release reset, with no iFrameEnd → no oDVAL.
- First detection: ch0 mask over x 100..103, y 50..53 (16 px), then iFrameEnd → oDVAL exactly 51 cycles later with oX[ch0]=101, oY[ch0]=51, oFound=2'b01. Ch1 stays 0.
- EMA: next frame uses block x 200..203, y 50..53 → oX[ch0]=101+((201−101)>>>2)=126, oY=51. Repeat with x 0..3 → 126+((1−126)>>>2)=126−32=94.
- Loss and reacquire: frame with 15 ch0 pixels → oFound[0]=0, oX holds 94. Next frame with a 16 px block centred at 300 → oX[ch0]=300, loaded directly.
- Drop and overlap: second iFrameEnd 20 cycles after the first → oDrop pulses once, the first frame's results still commit at cycle 51, and pixels after the dropped frame end count toward the next frame only.
- Boundary: pixel with iMask set in the same cycle as iFrameEnd is counted in the finishing frame. iRST pulsed at cycle 30 of a sequence → no oDVAL and outputs return to 0.
